// File: rtl/surf_cout_word_capture.sv
// surf_cout_word_capture: frames the 4-bit COUT nibble stream into 32-bit words on sync_i.
// Optional training-pattern comparator and error counter: define SURF_COUT_PATTERN_CHECK_EN.
`timescale 1ns/1ps
module surf_cout_word_capture #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A_C3F0,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                 sysclk_i,
  input  logic                 rst_n_i,
  input  logic                 sync_i,
  input  logic [3:0]           cout_i,
  input  logic                 cout_capture_i,
  input  logic                 cout_enable_i,
  output logic [31:0]          cout_data_o,
  output logic                 cout_valid_o,
  output logic                 cout_biterr_o,
  output logic [CNT_WIDTH-1:0] cout_errcnt_o,
  output logic                 cout_misalign_o
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  cnt_r;
  logic [2:0]  idx_s;
  logic [4:0]  lsb_s;
  logic        word_start_s;
  logic        word_done_s;
  logic        arm_s;
  logic [31:0] asm_r;
  logic [31:0] asm_nxt_s;
  logic        req_r;
  logic        cap_word_r;
  logic        fin_r;
  logic        fin_deliver_r;
  logic [31:0] fin_word_r;
  logic [31:0] data_r;
  logic        valid_r;
  logic        misalign_r;

  assign idx_s        = sync_i ? 3'd0 : cnt_r;
  assign word_start_s = (idx_s == 3'd0);
  assign word_done_s  = (idx_s == 3'd7) && (state_r != ST_UNSYNC);
  assign arm_s        = cout_capture_i && (state_r == ST_TRAIN) && !req_r;
  assign lsb_s        = {3'd7 - idx_s, 2'b00};

  // Word assembly: nibble 0 restarts the word, nibble k lands MSB-first in its slot.
  always_comb begin
    if (word_start_s) begin
      asm_nxt_s = 32'd0;
    end else begin
      asm_nxt_s = asm_r;
    end
    asm_nxt_s[lsb_s +: 4] = cout_i;
  end

  // Frame state only moves on nibble-0 edges so the word in flight keeps its mode.
  always_comb begin
    state_nxt_s = state_r;
    if (word_start_s) begin
      case (state_r)
        ST_UNSYNC: state_nxt_s = sync_i ? ST_TRAIN : ST_UNSYNC;
        ST_TRAIN:  state_nxt_s = cout_enable_i ? ST_RUN : ST_TRAIN;
        ST_RUN:    state_nxt_s = cout_enable_i ? ST_RUN : ST_TRAIN;
        default:   state_nxt_s = ST_UNSYNC;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_UNSYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Nibble framing, capture request and the word-completion stage.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r         <= 3'd0;
      asm_r         <= 32'd0;
      misalign_r    <= 1'b0;
      req_r         <= 1'b0;
      cap_word_r    <= 1'b0;
      fin_r         <= 1'b0;
      fin_deliver_r <= 1'b0;
      fin_word_r    <= 32'd0;
    end else begin
      cnt_r      <= idx_s + 3'd1;
      asm_r      <= asm_nxt_s;
      misalign_r <= sync_i && (state_r != ST_UNSYNC) && (cnt_r != 3'd0);
      // A word is a capture word if the request is armed when it starts, including on the arm edge.
      if (word_start_s) begin
        cap_word_r <= req_r || arm_s;
      end
      if (word_done_s && cap_word_r) begin
        req_r <= 1'b0;
      end else if (arm_s) begin
        req_r <= 1'b1;
      end
      fin_r <= word_done_s;
      if (word_done_s) begin
        fin_word_r    <= asm_nxt_s;
        fin_deliver_r <= (state_r == ST_RUN) || cap_word_r;
      end
    end
  end

  // Delivered-word output register.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_r <= 1'b0;
      data_r  <= 32'd0;
    end else begin
      valid_r <= fin_r && fin_deliver_r;
      if (fin_r && fin_deliver_r) begin
        data_r <= fin_word_r;
      end
    end
  end

  assign cout_data_o     = data_r;
  assign cout_valid_o    = valid_r;
  assign cout_misalign_o = misalign_r;

`ifdef SURF_COUT_PATTERN_CHECK_EN
  logic                 fin_check_r;
  logic                 biterr_r;
  logic [CNT_WIDTH-1:0] errcnt_r;
  logic                 mismatch_s;

  assign mismatch_s = fin_r && fin_check_r && (fin_word_r != TRAIN_PATTERN);

  // Training comparator; arming a capture clears the count and wins over a same-edge increment.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fin_check_r <= 1'b0;
      biterr_r    <= 1'b0;
      errcnt_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      if (word_done_s) begin
        fin_check_r <= (state_r == ST_TRAIN);
      end
      biterr_r <= mismatch_s;
      if (arm_s) begin
        errcnt_r <= {CNT_WIDTH{1'b0}};
      end else if (mismatch_s && (errcnt_r != {CNT_WIDTH{1'b1}})) begin
        errcnt_r <= errcnt_r + CNT_WIDTH'(1);
      end
    end
  end

  assign cout_biterr_o = biterr_r;
  assign cout_errcnt_o = errcnt_r;
`else
  assign cout_biterr_o = 1'b0;
  assign cout_errcnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_surf_cout_word_capture.sv
// Randomised scoreboard bench for surf_cout_word_capture; honours SURF_COUT_PATTERN_CHECK_EN.
`timescale 1ns/1ps
module tb_surf_cout_word_capture;
  localparam int          CW      = 2;
  localparam int          ERR_MAX = (1 << CW) - 1;
  localparam logic [31:0] PAT     = 32'hA55A_C3F0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync;
  logic [3:0]    nib;
  logic          cap;
  logic          en;
  logic [31:0]   data;
  logic          valid;
  logic          biterr;
  logic [CW-1:0] errcnt;
  logic          mis;

  surf_cout_word_capture #(.TRAIN_PATTERN(PAT), .CNT_WIDTH(CW)) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .cout_i(nib),
    .cout_capture_i(cap), .cout_enable_i(en), .cout_data_o(data),
    .cout_valid_o(valid), .cout_biterr_o(biterr), .cout_errcnt_o(errcnt),
    .cout_misalign_o(mis)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          valid;
    logic [31:0] data;
    bit          biterr;
    bit          mis;
    int          errcnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: mode 0 = unsynced, 1 = training, 2 = running.
  int          m_mode, m_nat, m_errcnt, m_rep;
  logic [31:0] m_word, p_word;
  bit          m_cap_word, m_armed, p_pend, p_deliver, p_check;

  task automatic model_reset();
    m_mode = 0; m_nat = 0; m_errcnt = 0; m_rep = 0; m_word = 32'd0;
    m_cap_word = 1'b0; m_armed = 1'b0; p_pend = 1'b0; p_deliver = 1'b0;
    p_check = 1'b0; p_word = 32'd0;
  endtask

  task automatic model_step(input int e, input bit s, input logic [3:0] n, input bit c, input bit en_v);
    exp_t r;
    int idx;
    r.cyc = e; r.valid = 1'b0; r.data = 32'd0; r.biterr = 1'b0;
    if (p_pend) begin
      if (p_deliver) begin
        r.valid = 1'b1;
        r.data  = p_word;
      end
`ifdef SURF_COUT_PATTERN_CHECK_EN
      if (p_check && (p_word != PAT)) begin
        r.biterr = 1'b1;
        if (m_errcnt < ERR_MAX) m_errcnt++;
      end
`endif
    end
    r.mis = s && (m_mode != 0) && (m_nat != 0);
    if (c && (m_mode == 1) && !m_armed) begin
      m_armed  = 1'b1;
      m_errcnt = 0;
    end
    idx = s ? 0 : m_nat;
    if (idx == 0) begin
      m_word     = 32'd0;
      m_cap_word = m_armed;
      case (m_mode)
        0:       if (s) m_mode = 1;
        1:       if (en_v) m_mode = 2;
        default: if (!en_v) m_mode = 1;
      endcase
    end
    m_word = m_word | (32'(n) << (28 - 4 * idx));
    p_pend = 1'b0;
    if ((idx == 7) && (m_mode != 0)) begin
      p_pend    = 1'b1;
      p_deliver = (m_mode == 2) || m_cap_word;
      p_check   = (m_mode == 1);
      p_word    = m_word;
      if (m_cap_word) m_armed = 1'b0;
    end
    m_nat = (idx + 1) % 8;
    r.errcnt = m_errcnt;
    if (r.valid || r.biterr || r.mis || (m_errcnt != m_rep)) begin
      q.push_back(r);
      m_rep = m_errcnt;
    end
  endtask

  // Monitor: consumes one expectation whenever the DUT shows a pulse or a count change.
  initial begin
    int   last;
    exp_t e;
    bit   have, hit;
    last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = int'(errcnt);
      end else begin
        while ((q.size() > 0) && (q[0].cyc < cyc)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_expect: event for edge %0d not consumed by edge %0d", q[0].cyc, cyc);
          void'(q.pop_front());
        end
        have = (q.size() > 0) && (q[0].cyc == cyc);
        hit  = valid || biterr || mis || (int'(errcnt) != last);
        if (have) begin
          e = q.pop_front();
        end else begin
          e.cyc = cyc; e.valid = 1'b0; e.data = 32'd0; e.biterr = 1'b0;
          e.mis = 1'b0; e.errcnt = last;
        end
        if (have || hit) begin
          chk("valid", 32'(valid), 32'(e.valid));
          chk("biterr", 32'(biterr), 32'(e.biterr));
          chk("misalign", 32'(mis), 32'(e.mis));
          chk("errcnt", 32'(errcnt), 32'(e.errcnt));
          if (e.valid) chk("data", data, e.data);
        end
        last = int'(errcnt);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_biterr"}, 32'(biterr), 32'd0);
    chk({tag, "_errcnt"}, 32'(errcnt), 32'd0);
    chk({tag, "_misalign"}, 32'(mis), 32'd0);
  endtask

  bit          pat_word;
  logic [31:0] rnd_word;
  logic [31:0] pat_v;

  task automatic drive(input int i, input bit quiet);
    int idx;
    bit s;
    s   = !quiet && ((i == 10) || ((i > 10) && ($urandom_range(0, 59) == 0)));
    cap = !quiet && ($urandom_range(0, 11) == 0);
    if (i < 400) en = 1'b0;
    else if ($urandom_range(0, 39) == 0) en = !en;
    idx = s ? 0 : m_nat;
    if (idx == 0) begin
      pat_word = en ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rnd_word = $urandom;
    end
    pat_v = pat_word ? PAT : rnd_word;
    nib   = 4'(pat_v >> (28 - 4 * idx));
    if (pat_word && ($urandom_range(0, 15) == 0)) nib = nib ^ 4'($urandom_range(1, 15));
    sync = s;
    model_step(cyc + 1, s, nib, cap, en);
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; cap = 1'b0; en = 1'b0; nib = 4'd0;
    pat_word = 1'b0; rnd_word = 32'd0; pat_v = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2500) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        q.delete();
        model_reset();
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      drive(i, 1'b0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 24; i++) begin
      drive(4000 + i, 1'b1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
